// File: rtl/irq_priority_arbiter_if.sv
// Request/grant bundle for irq_priority_arbiter: request lines and masks in,
// winner index out on a valid/ready handshake, plus pending-state visibility.
interface irq_priority_arbiter_if #(
    parameter int N = 8
);
    localparam int IDXW = $clog2(N);

    logic [N-1:0]    req;
    logic [N-1:0]    mask;
    logic            out_valid;
    logic [IDXW-1:0] out_idx;
    logic            out_ready;
    logic [N-1:0]    pending;
    logic            any_pending;

    // Handshake: out_idx transfers on a cycle where out_valid && out_ready;
    // once out_valid rises, out_idx and out_valid hold until that transfer.
    modport master (
        output req, mask, out_ready,
        input  out_valid, out_idx, pending, any_pending
    );

    modport slave (
        input  req, mask, out_ready,
        output out_valid, out_idx, pending, any_pending
    );
endinterface

// File: rtl/irq_priority_arbiter.sv
// Registered interrupt/request arbiter: captures rising edges into sticky
// pending bits and grants one eligible source at a time by fixed or rotating priority.
module irq_priority_arbiter #(
    parameter int      N           = 8,
    parameter bit      ROUND_ROBIN = 1'b0,
    localparam int     IDXW        = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    irq_priority_arbiter_if.slave bus,
    output logic                 o_state,
    output logic [IDXW-1:0]      o_ptr
);

    typedef enum logic {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [N-1:0]    r_req_q;
    logic [N-1:0]    r_pending;
    logic            r_out_valid;
    logic [IDXW-1:0] r_out_idx;
    logic [IDXW-1:0] r_ptr;

    logic [N-1:0]    w_edge;
    logic [N-1:0]    w_elig;
    logic [N-1:0]    w_clr;
    logic [IDXW-1:0] w_fixed_idx;
    logic [IDXW-1:0] w_rr_idx;
    logic [IDXW-1:0] w_winner;
    logic            w_load;
    logic            w_handshake;
    int              v_dist;
    int              v_best;

    assign w_edge = bus.req & ~r_req_q;
    assign w_elig = r_pending & bus.mask;

    always_comb begin
        w_fixed_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (w_elig[i]) w_fixed_idx = IDXW'(i);
        end
    end

    // Rotating search: rank each source by its distance past ptr (mod N) and
    // keep the nearest eligible one, so ptr itself is considered last.
    always_comb begin
        w_rr_idx = '0;
        v_best   = N;
        v_dist   = 0;
        for (int i = 0; i < N; i++) begin
            v_dist = i - int'(r_ptr) - 1;
            if (v_dist < 0) v_dist = v_dist + N;
            if (w_elig[i] && (v_dist < v_best)) begin
                v_best   = v_dist;
                w_rr_idx = IDXW'(i);
            end
        end
    end

    assign w_winner = ROUND_ROBIN ? w_rr_idx : w_fixed_idx;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (|w_elig)       w_state_nxt = S_GRANT;
            S_GRANT: if (bus.out_ready) w_state_nxt = S_IDLE;
            default:                    w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_load      = 1'b0;
        w_handshake = 1'b0;
        case (r_state)
            S_IDLE:  w_load      = |w_elig;
            S_GRANT: w_handshake = bus.out_ready;
            default: ;
        endcase
    end

    assign w_clr = w_handshake ? (N'(1) << r_out_idx) : '0;

    // Set-wins: a fresh edge on the granted source survives its own clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_req_q     <= '0;
            r_pending   <= '0;
            r_out_valid <= 1'b0;
            r_out_idx   <= '0;
            r_ptr       <= IDXW'(N - 1);
        end else begin
            r_state   <= w_state_nxt;
            r_req_q   <= bus.req;
            r_pending <= (r_pending & ~w_clr) | w_edge;
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_idx   <= w_winner;
            end else if (w_handshake) begin
                r_out_valid <= 1'b0;
            end
            if (w_handshake) r_ptr <= r_out_idx;
        end
    end

    assign bus.out_valid   = r_out_valid;
    assign bus.out_idx     = r_out_idx;
    assign bus.pending     = r_pending;
    assign bus.any_pending = |w_elig;
    assign o_state         = r_state;
    assign o_ptr           = r_ptr;

endmodule

// File: tb/tb_irq_priority_arbiter.sv
// Directed bench for irq_priority_arbiter: a fixed-priority N=8 instance and a
// round-robin N=5 instance driven through their interfaces.
module tb_irq_priority_arbiter;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  irq_priority_arbiter_if #(.N(8)) bus_a ();
  irq_priority_arbiter_if #(.N(5)) bus_b ();

  logic       state_a;
  logic       state_b;
  logic [2:0] ptr_a;
  logic [2:0] ptr_b;

  irq_priority_arbiter #(.N(8), .ROUND_ROBIN(1'b0)) dut_fixed (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus_a.slave),
    .o_state (state_a),
    .o_ptr   (ptr_a)
  );

  irq_priority_arbiter #(.N(5), .ROUND_ROBIN(1'b1)) dut_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus_b.slave),
    .o_state (state_b),
    .o_ptr   (ptr_b)
  );

  // scoreboard
  int         total = 0;
  int         bad   = 0;
  logic [2:0] exp_q[$];
  logic [2:0] exp_idx;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input bit sel_rr, input int max_cycles, input string tag);
    int n;
    logic v;
    n = 0;
    v = 1'b0;
    while (!v && n < max_cycles) begin
      step();
      n++;
      v = sel_rr ? bus_b.out_valid : bus_a.out_valid;
    end
    check(tag, v, 1);
  endtask

  initial begin
    rst_n           = 1'b0;
    bus_a.req       = 8'hFF;
    bus_a.mask      = 8'hFF;
    bus_a.out_ready = 1'b0;
    bus_b.req       = 5'h00;
    bus_b.mask      = 5'h1F;
    bus_b.out_ready = 1'b0;

    // reset and idle
    step();
    step();
    rst_n = 1'b1;
    check("rst_valid", bus_a.out_valid, 0);
    check("rst_idx", bus_a.out_idx, 0);
    check("rst_pending", bus_a.pending, 0);
    check("rst_any", bus_a.any_pending, 0);
    check("rst_ptr", ptr_a, 7);
    check("rst_state", state_a, 0);
    step();
    check("first_edge_pending", bus_a.pending, 8'hFF);
    check("first_edge_valid", bus_a.out_valid, 0);
    step();
    check("second_edge_valid", bus_a.out_valid, 1);
    check("second_edge_idx", bus_a.out_idx, 7);

    // drain the eight reset-time events, highest first
    bus_a.req       = 8'h00;
    bus_a.out_ready = 1'b1;
    for (int k = 6; k >= 0; k--) begin
      wait_valid(1'b0, 4, "drain_valid");
      check($sformatf("drain_idx_%0d", k), bus_a.out_idx, k);
    end
    step();
    check("drain_pending", bus_a.pending, 0);
    check("drain_valid_low", bus_a.out_valid, 0);

    // fixed priority: sources 5 and 2 together
    bus_a.req = 8'b0010_0100;
    step();
    bus_a.req = 8'h00;
    check("fp_pending", bus_a.pending, 8'h24);
    step();
    check("fp_valid5", bus_a.out_valid, 1);
    check("fp_idx5", bus_a.out_idx, 5);
    step();
    check("fp_gap", bus_a.out_valid, 0);
    step();
    check("fp_valid2", bus_a.out_valid, 1);
    check("fp_idx2", bus_a.out_idx, 2);
    step();
    check("fp_end_valid", bus_a.out_valid, 0);
    check("fp_end_pending", bus_a.pending, 0);

    // backpressure: grant of 3 held while 7 arrives
    bus_a.out_ready = 1'b0;
    bus_a.req = 8'h08;
    step();
    bus_a.req = 8'h00;
    step();
    check("bp_idx3", bus_a.out_idx, 3);
    bus_a.req = 8'h80;
    step();
    bus_a.req = 8'h00;
    for (int k = 0; k < 10; k++) begin
      check("bp_hold_valid", bus_a.out_valid, 1);
      check("bp_hold_idx", bus_a.out_idx, 3);
      step();
    end
    check("bp_pending", bus_a.pending, 8'h88);
    bus_a.out_ready = 1'b1;
    step();
    check("bp_release", bus_a.out_valid, 0);
    step();
    check("bp_next_valid", bus_a.out_valid, 1);
    check("bp_next_idx", bus_a.out_idx, 7);
    step();
    check("bp_end_pending", bus_a.pending, 0);

    // masking: source 6 captured while disabled
    bus_a.mask = 8'h0F;
    bus_a.req  = 8'h40;
    step();
    bus_a.req = 8'h00;
    check("mask_pending", bus_a.pending, 8'h40);
    check("mask_any", bus_a.any_pending, 0);
    step();
    step();
    check("mask_no_grant", bus_a.out_valid, 0);
    bus_a.mask = 8'hFF;
    #1;
    check("unmask_any", bus_a.any_pending, 1);
    wait_valid(1'b0, 3, "unmask_valid");
    check("unmask_idx", bus_a.out_idx, 6);
    step();
    check("unmask_pending", bus_a.pending, 0);

    // set-wins: source 4 re-fires on its own handshake edge
    bus_a.req = 8'h10;
    step();
    bus_a.req = 8'h00;
    step();
    check("sw_idx_first", bus_a.out_idx, 4);
    bus_a.req = 8'h10;
    step();
    bus_a.req = 8'h00;
    check("sw_pending_kept", bus_a.pending, 8'h10);
    check("sw_valid_low", bus_a.out_valid, 0);
    step();
    check("sw_second_valid", bus_a.out_valid, 1);
    check("sw_second_idx", bus_a.out_idx, 4);
    step();
    check("sw_end_pending", bus_a.pending, 0);

    // reset during an outstanding grant discards the event
    bus_a.out_ready = 1'b0;
    bus_a.req = 8'h04;
    step();
    bus_a.req = 8'h00;
    step();
    check("mr_valid_before", bus_a.out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mr_valid_cleared", bus_a.out_valid, 0);
    check("mr_pending_cleared", bus_a.pending, 0);
    check("mr_state_cleared", state_a, 0);
    rst_n = 1'b1;
    step();
    step();
    check("mr_no_replay", bus_a.out_valid, 0);

    // round-robin N=5: all sources held pending, then drained
    check("rr_ptr_reset", ptr_b, 4);
    bus_b.out_ready = 1'b1;
    bus_b.req = 5'h1F;
    step();
    bus_b.req = 5'h00;
    check("rr_pending_all", bus_b.pending, 5'h1F);
    for (int g = 0; g < 10; g++) exp_q.push_back(3'(g % 5));
    for (int g = 0; g < 10; g++) begin
      wait_valid(1'b1, 4, "rr_valid");
      exp_idx = exp_q.pop_front();
      check($sformatf("rr_idx_%0d", g), bus_b.out_idx, exp_idx);
      if (g < 5) begin
        bus_b.req = 5'b00001 << exp_idx;
        step();
        bus_b.req = 5'h00;
        check("rr_pending_held", bus_b.pending, 5'h1F);
      end
    end
    step();
    check("rr_end_pending", bus_b.pending, 0);
    check("rr_end_ptr", ptr_b, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
